// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter:
// state encoding and default widths.
package wb_port_arbiter_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_AW   = 5;

  typedef logic state_t;

  localparam state_t ST_PRIO_A  = 1'b0;
  localparam state_t ST_FORCE_B = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_mux2x5.sv
// 2:1 mux for 5-bit register addresses.
// Ports: d0/d1 data in, s select (1 picks d1), y out.
module mux2x5
  import wb_port_arbiter_pkg::*;
(
  input  logic [WB_AW-1:0] d0,
  input  logic [WB_AW-1:0] d1,
  input  logic             s,
  output logic [WB_AW-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between
// A (execute result) and B (load result). A has priority;
// B is forced after STARVE_LIMIT blocked cycles.
// Ports: clk, rst (async, active-high), hold (freeze);
//   a_valid/a_ready/a_rd/a_data, b_valid/b_ready/b_rd/b_data
//   requester handshakes; wb_we/wb_rd/wb_data registered
//   write port; starve_cnt current B wait count.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int AW           = WB_AW,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            wb_we,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [3:0]      starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  state_t          state;
  logic            grant_a;
  logic            grant_b;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // The saturated counter value is the FORCE_B state itself.
  assign state = (cnt_q == LIMIT) ? ST_FORCE_B : ST_PRIO_A;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !hold) begin
      if (state == ST_FORCE_B) begin
        grant_b = b_valid;
        grant_a = a_valid & ~b_valid;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid & ~a_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  mux2x5 u_rd_mux (
    .d0 (a_rd),
    .d1 (b_rd),
    .s  (grant_b),
    .y  (win_rd)
  );

  assign win_data = grant_b ? b_data : a_data;

  always_comb begin
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (!hold) begin
      if (!b_valid || grant_b) begin
        cnt_d = 4'd0;
      end else if (cnt_q < LIMIT) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (grant_a || grant_b) begin
        // x0 writes are consumed but never reach the file.
        we_d   = (win_rd != '0);
        rd_d   = win_rd;
        data_d = win_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign wb_we      = we_q;
  assign wb_rd      = rd_q;
  assign wb_data    = data_q;
  assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter.
// Inputs change on negedge; outputs sampled #1 after edges.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  starve_cnt;

  int pass_cnt;
  int total_cnt;

  wb_port_arbiter #(
    .XLEN         (32),
    .AW           (5),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    total_cnt++;
    if (a_ready !== 1'b0)
      $display("FAIL reset_a_ready got=%b exp=0", a_ready);
    else pass_cnt++;
    total_cnt++;
    if (b_ready !== 1'b0)
      $display("FAIL reset_b_ready got=%b exp=0", b_ready);
    else pass_cnt++;
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b0)
      $display("FAIL reset_wb_we got=%b exp=0", wb_we);
    else pass_cnt++;
    total_cnt++;
    if (starve_cnt !== 4'd0)
      $display("FAIL reset_cnt got=%0d exp=0", starve_cnt);
    else pass_cnt++;
  endtask

  task automatic test_a_only();
    @(negedge clk);
    a_valid = 1'b1;
    a_rd = 5'd5;
    a_data = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1)
      $display("FAIL aonly_ready got=%b exp=1", a_ready);
    else pass_cnt++;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd5 ||
        wb_data !== 32'hDEADBEEF)
      $display("FAIL aonly_wb got=%b/%0d/%h exp=1/5/deadbeef",
               wb_we, wb_rd, wb_data);
    else pass_cnt++;
    @(negedge clk);
    a_valid = 1'b0;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b0)
      $display("FAIL aonly_we_drop got=%b exp=0", wb_we);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic       exp_b;
    logic [3:0] exp_cnt;
    @(negedge clk);
    a_valid = 1'b1;
    a_rd = 5'd1;
    a_data = 32'hA;
    b_valid = 1'b1;
    b_rd = 5'd2;
    b_data = 32'hB;
    for (int i = 0; i < 8; i++) begin
      exp_b   = (i % 4) == 3;
      exp_cnt = exp_b ? 4'd0 : 4'((i % 4) + 1);
      if (i != 0) @(negedge clk);
      #1;
      total_cnt++;
      if (a_ready !== ~exp_b || b_ready !== exp_b)
        $display("FAIL cont_grant[%0d] got=a%b/b%b exp=a%b/b%b",
                 i, a_ready, b_ready, ~exp_b, exp_b);
      else pass_cnt++;
      edge_wait();
      total_cnt++;
      if (starve_cnt !== exp_cnt ||
          wb_rd !== (exp_b ? 5'd2 : 5'd1) || wb_we !== 1'b1)
        $display("FAIL cont_out[%0d] got=cnt%0d/rd%0d/we%b exp=cnt%0d/rd%0d/we1",
                 i, starve_cnt, wb_rd, wb_we, exp_cnt,
                 exp_b ? 2 : 1);
      else pass_cnt++;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_x0();
    @(negedge clk);
    b_valid = 1'b1;
    b_rd = 5'd0;
    b_data = 32'd7;
    #1;
    total_cnt++;
    if (b_ready !== 1'b1)
      $display("FAIL x0_ready got=%b exp=1", b_ready);
    else pass_cnt++;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd7)
      $display("FAIL x0_wb got=%b/%0d/%0d exp=0/0/7",
               wb_we, wb_rd, wb_data);
    else pass_cnt++;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    hold = 1'b1;
    a_valid = 1'b1;
    a_rd = 5'd9;
    a_data = 32'h55;
    b_valid = 1'b1;
    b_rd = 5'd3;
    b_data = 32'h33;
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      total_cnt++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
        $display("FAIL hold_ready[%0d] got=a%b/b%b exp=a0/b0",
                 i, a_ready, b_ready);
      else pass_cnt++;
      edge_wait();
      total_cnt++;
      if (wb_we !== 1'b0 || starve_cnt !== 4'd0)
        $display("FAIL hold_out[%0d] got=we%b/cnt%0d exp=we0/cnt0",
                 i, wb_we, starve_cnt);
      else pass_cnt++;
    end
    @(negedge clk);
    hold = 1'b0;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL hold_release got=a%b/b%b exp=a1/b0",
               a_ready, b_ready);
    else pass_cnt++;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd9 ||
        wb_data !== 32'h55 || starve_cnt !== 4'd1)
      $display("FAIL hold_write got=%b/%0d/%h/cnt%0d exp=1/9/55/cnt1",
               wb_we, wb_rd, wb_data, starve_cnt);
    else pass_cnt++;
    @(negedge clk);
    a_valid = 1'b0;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd3 || starve_cnt !== 4'd0)
      $display("FAIL hold_b_write got=%b/%0d/cnt%0d exp=1/3/cnt0",
               wb_we, wb_rd, starve_cnt);
    else pass_cnt++;
    @(negedge clk);
    b_valid = 1'b0;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b0)
      $display("FAIL hold_single got=%b exp=0", wb_we);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_valid = 1'b1;
    a_rd = 5'd4;
    a_data = 32'h44;
    b_valid = 1'b1;
    b_rd = 5'd6;
    b_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      edge_wait();
    end
    total_cnt++;
    if (wb_we !== 1'b1 || starve_cnt !== 4'd3)
      $display("FAIL arst_pre got=we%b/cnt%0d exp=we1/cnt3",
               wb_we, starve_cnt);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (wb_we !== 1'b0 || starve_cnt !== 4'd0 ||
        wb_rd !== 5'd0 || a_ready !== 1'b0)
      $display("FAIL arst_now got=we%b/cnt%0d/rd%0d/ar%b exp=0/0/0/0",
               wb_we, starve_cnt, wb_rd, a_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL arst_first got=a%b/b%b exp=a1/b0",
               a_ready, b_ready);
    else pass_cnt++;
    edge_wait();
    total_cnt++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd4 || starve_cnt !== 4'd1)
      $display("FAIL arst_after got=%b/%0d/cnt%0d exp=1/4/cnt1",
               wb_we, wb_rd, starve_cnt);
    else pass_cnt++;
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    hold = 1'b0;
    a_valid = 1'b0;
    a_rd = '0;
    a_data = '0;
    b_valid = 1'b0;
    b_rd = '0;
    b_data = '0;
    test_reset();
    test_a_only();
    test_contention();
    test_x0();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
